// File: rtl/sdram_arbiter.sv
// Two-port burst arbiter in front of a single SDRAM controller command/data port.
// Define SDRAM_ARB_FAIRNESS_EN to add the p1 anti-starvation counter (otherwise strict p0 priority).
module sdram_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_166,
    input  logic              rst,
    input  logic              p0_req,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_we,
    input  logic [LEN_W-1:0]  p0_len,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_wr_strobe,
    output logic              p0_rd_valid,
    output logic              p0_done,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_we,
    input  logic [LEN_W-1:0]  p1_len,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic              p1_wr_strobe,
    output logic              p1_rd_valid,
    output logic              p1_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [LEN_W-1:0]  m_len,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_wr_strobe,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rd_valid,
    input  logic              m_done
);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_XFER} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_grant;           // 0 = p0 owns the controller, 1 = p1
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [LEN_W-1:0]  r_len;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_p0_rd_valid;
    logic              r_p1_rd_valid;
    logic              w_grant_now;
    logic              w_p1_wins;
    logic              w_active;

`ifdef SDRAM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] r_starve;
    logic             w_starved;

    assign w_starved = (r_starve == CNT_W'(STARVE_MAX));
    assign w_p1_wins = p1_req & (~p0_req | w_starved);

    // Counts p0 wins that left p1 waiting; saturates, cleared by any p1 win.
    always_ff @(posedge clk_166) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_grant_now) begin
            if (w_p1_wins)
                r_starve <= '0;
            else if (p1_req && !w_starved)
                r_starve <= r_starve + 1'b1;
        end
    end
`else
    assign w_p1_wins = p1_req & ~p0_req;
`endif

    // Ack is combinational so a request seen in IDLE is acknowledged in that same cycle.
    assign w_grant_now = (r_state == S_IDLE) & (p0_req | p1_req) & ~rst;
    assign w_active    = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (p0_req || p1_req) w_state_nxt = S_CMD;
            S_CMD:   if (m_ready)          w_state_nxt = S_XFER;
            S_XFER:  if (m_done)           w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_166) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= 1'b0;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_len         <= '0;
            r_rd_data     <= '0;
            r_p0_rd_valid <= 1'b0;
            r_p1_rd_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_p0_rd_valid <= w_active & m_rd_valid & ~r_grant;
            r_p1_rd_valid <= w_active & m_rd_valid &  r_grant;
            if (w_active && m_rd_valid)
                r_rd_data <= m_rd_data;
            if (w_grant_now) begin
                r_grant <= w_p1_wins;
                r_addr  <= w_p1_wins ? p1_addr : p0_addr;
                r_we    <= w_p1_wins ? p1_we   : p0_we;
                r_len   <= w_p1_wins ? p1_len  : p0_len;
            end
        end
    end

    assign p0_ack       = w_grant_now & ~w_p1_wins;
    assign p1_ack       = w_grant_now &  w_p1_wins;
    assign p0_done      = (r_state == S_XFER) & m_done & ~r_grant;
    assign p1_done      = (r_state == S_XFER) & m_done &  r_grant;
    assign p0_wr_strobe = w_active & m_wr_strobe & ~r_grant;
    assign p1_wr_strobe = w_active & m_wr_strobe &  r_grant;
    assign p0_rd_valid  = r_p0_rd_valid;
    assign p1_rd_valid  = r_p1_rd_valid;
    assign rd_data      = r_rd_data;
    assign m_valid      = (r_state == S_CMD);
    assign m_addr       = r_addr;
    assign m_we         = r_we;
    assign m_len        = r_len;
    assign m_wdata      = w_active ? (r_grant ? p1_wdata : p0_wdata) : '0;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 8;

  logic              clk_166 = 1'b0;
  logic              rst = 1'b1;
  logic              p0_req = 1'b0, p1_req = 1'b0;
  logic [ADDR_W-1:0] p0_addr = '0, p1_addr = '0;
  logic              p0_we = 1'b0, p1_we = 1'b0;
  logic [LEN_W-1:0]  p0_len = '0, p1_len = '0;
  logic [DATA_W-1:0] p0_wdata = '0, p1_wdata = '0;
  logic              p0_ack, p1_ack, p0_wr_strobe, p1_wr_strobe;
  logic              p0_rd_valid, p1_rd_valid, p0_done, p1_done;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_wdata;
  logic              m_wr_strobe = 1'b0;
  logic [DATA_W-1:0] m_rd_data = '0;
  logic              m_rd_valid = 1'b0;
  logic              m_done = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit fair_en;

  sdram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .STARVE_MAX(4)
  ) dut (
    .clk_166(clk_166), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_len(p0_len), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_wr_strobe(p0_wr_strobe), .p0_rd_valid(p0_rd_valid), .p0_done(p0_done),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_len(p1_len), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_wr_strobe(p1_wr_strobe), .p1_rd_valid(p1_rd_valid), .p1_done(p1_done),
    .rd_data(rd_data),
    .m_valid(m_valid), .m_addr(m_addr), .m_we(m_we), .m_len(m_len), .m_ready(m_ready),
    .m_wdata(m_wdata), .m_wr_strobe(m_wr_strobe),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .m_done(m_done)
  );

  always #3 clk_166 = ~clk_166;

  task automatic tick();
    @(posedge clk_166);
    #1;
  endtask

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (ok) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  initial begin
`ifdef SDRAM_ARB_FAIRNESS_EN
    fair_en = 1'b1;
`else
    fair_en = 1'b0;
`endif
    tick(); tick();
    chk("rst_m_valid", m_valid === 1'b0);
    chk("rst_m_addr", m_addr === '0);
    chk("rst_rd_data", rd_data === '0);
    chk("rst_acks", {p0_ack, p1_ack, p0_done, p1_done} === 4'b0000);
    rst = 1'b0;
    tick();

    p1_req = 1'b1; p1_addr = 24'h000100; p1_len = 8'd3; p1_we = 1'b0;
    #1;
    chk("p1rd_ack", {p0_ack, p1_ack} === 2'b01);
    chk("p1rd_mvalid_c0", m_valid === 1'b0);
    tick();
    p1_req = 1'b0; p1_addr = 24'h000055; p1_len = 8'd9; m_ready = 1'b1;
    #1;
    chk("p1rd_mvalid_c1", m_valid === 1'b1);
    chk("p1rd_maddr", m_addr === 24'h000100);
    chk("p1rd_mlen", m_len === 8'd3);
    chk("p1rd_mwe", m_we === 1'b0);
    tick();
    m_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      m_rd_valid = 1'b1; m_rd_data = 16'hA000 + 16'(i);
      tick();
      chk("p1rd_rvalid", {p0_rd_valid, p1_rd_valid} === 2'b01);
      chk("p1rd_rdata", rd_data === 16'hA000 + 16'(i));
    end
    m_rd_valid = 1'b0; m_done = 1'b1;
    #1;
    chk("p1rd_done", {p0_done, p1_done} === 2'b01);
    tick();
    m_done = 1'b0;
    chk("p1rd_after", {p1_rd_valid, p1_done, m_valid} === 3'b000);

    m_wr_strobe = 1'b1; m_rd_valid = 1'b1; m_done = 1'b1; m_rd_data = 16'h5A5A;
    #1;
    chk("idle_strobes", {p0_wr_strobe, p1_wr_strobe, p0_done, p1_done} === 4'b0000);
    tick();
    chk("idle_rvalid", {p0_rd_valid, p1_rd_valid} === 2'b00);
    chk("idle_rdata_hold", rd_data === 16'hA003);
    m_wr_strobe = 1'b0; m_rd_valid = 1'b0; m_done = 1'b0;

    p0_req = 1'b1; p0_addr = 24'h000200; p0_we = 1'b1; p0_len = 8'd1; p0_wdata = 16'h1111;
    p1_req = 1'b1; p1_addr = 24'h000300; p1_we = 1'b0; p1_len = 8'd0;
    #1;
    chk("both_ack", {p0_ack, p1_ack} === 2'b10);
    tick();
    p0_req = 1'b0;
    #1;
    chk("both_maddr", m_addr === 24'h000200);
    chk("both_mwe_len", {m_we, m_len} === {1'b1, 8'd1});
    chk("both_no_p1ack", p1_ack === 1'b0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; m_wr_strobe = 1'b1;
    #1;
    chk("wr_strobe0", {p0_wr_strobe, p1_wr_strobe} === 2'b10);
    chk("wr_wdata0", m_wdata === 16'h1111);
    tick();
    p0_wdata = 16'h2222;
    #1;
    chk("wr_strobe1", {p0_wr_strobe, p1_wr_strobe} === 2'b10);
    chk("wr_wdata1", m_wdata === 16'h2222);
    tick();
    m_wr_strobe = 1'b0; m_done = 1'b1;
    #1;
    chk("wr_done", {p0_done, p1_done} === 2'b10);
    chk("wr_done_no_p1ack", p1_ack === 1'b0);
    tick();
    m_done = 1'b0;
    #1;
    chk("p1_after_dead", {p0_ack, p1_ack} === 2'b01);
    tick();
    p1_req = 1'b0;
    chk("p1_maddr", m_addr === 24'h000300);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; m_done = 1'b1;
    #1;
    chk("p1_done2", {p0_done, p1_done} === 2'b01);
    tick();
    m_done = 1'b0;

    p0_req = 1'b1; p0_addr = 24'h000400; p0_we = 1'b0;
    #1;
    chk("stall_ack", p0_ack === 1'b1);
    tick();
    p0_req = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      p0_addr = 24'h000500 + 24'(i);
      #1;
      chk("stall_valid_addr", {m_valid, m_addr} === {1'b1, 24'h000400});
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("stall_released", m_valid === 1'b0);
    m_done = 1'b1;
    tick();
    m_done = 1'b0;

    p0_req = 1'b1; p1_req = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      bit exp_p1;
      exp_p1 = fair_en && (k == 4);
      p0_addr = 24'h000600 + 24'(k);
      p1_addr = 24'h000700 + 24'(k);
      #1;
      chk("fair_ack", {p0_ack, p1_ack} === {~exp_p1, exp_p1});
      tick();
      chk("fair_maddr", m_addr === (exp_p1 ? 24'h000700 + 24'(k) : 24'h000600 + 24'(k)));
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0; m_done = 1'b1;
      #1;
      chk("fair_done", {p0_done, p1_done} === {~exp_p1, exp_p1});
      tick();
      m_done = 1'b0;
    end
    p0_req = 1'b0; p1_req = 1'b0;

    p1_req = 1'b1; p1_addr = 24'h000800; p1_len = 8'd5;
    tick();
    p1_req = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0; m_rd_valid = 1'b1; m_rd_data = 16'hBEEF;
    tick();
    m_rd_valid = 1'b0;
    chk("xfer_rd", {p1_rd_valid, rd_data} === {1'b1, 16'hBEEF});
    rst = 1'b1; m_done = 1'b1;
    tick();
    chk("mid_rst_cmd", {m_valid, m_addr, m_len, m_we} === '0);
    chk("mid_rst_rd", {p1_rd_valid, rd_data} === '0);
    chk("mid_rst_done", {p0_done, p1_done, p0_ack, p1_ack} === 4'b0000);
    rst = 1'b0; m_done = 1'b0;
    p0_req = 1'b1; p0_addr = 24'h000900; p0_len = 8'd2;
    #1;
    chk("post_rst_ack", {p0_ack, p1_ack} === 2'b10);
    tick();
    p0_req = 1'b0;
    chk("post_rst_cmd", {m_valid, m_addr} === {1'b1, 24'h000900});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; m_done = 1'b1;
    tick();
    m_done = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
